// File: rtl/ov2640_sccb_master.sv
// rtl/ov2640_sccb_master.sv - SCCB 3-phase write master that drains the OV2640 config table
// Pins are registered from next-state values so every pin edge lands on a quarter boundary.
module ov2640_sccb_master #(
  parameter int          CLK_FREQ   = 50_000_000,
  parameter int          SCCB_FREQ  = 100_000,
  parameter logic [7:0]  DEV_ADDR   = 8'h60,
  parameter int          PWRUP_WAIT = 50_000,
  parameter int          RST_WAIT   = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [15:0] cfg_data,
  output logic        sccb_ok,
  output logic        busy,
  output logic        sio_c,
  output logic        sio_d_out,
  output logic        sio_d_oe
);

  localparam int DIV = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int QW  = $clog2(DIV);
  localparam logic [QW-1:0] Q_LAST     = QW'(DIV - 1);
  localparam logic [23:0]   PWRUP_LAST = 24'(PWRUP_WAIT - 1);
  localparam logic [23:0]   RST_LAST   = 24'(RST_WAIT - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_IDLE, S_SETTLE, S_START, S_BITS, S_STOP, S_GAP, S_RSTW
  } state_t;

  state_t        state, state_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [1:0]    qtr, qtr_n;
  logic [4:0]    bit_cnt, bit_n;
  logic [23:0]   wait_cnt, wait_n;
  logic [26:0]   frame, frame_n;
  logic          soft_rst, soft_rst_n;
  logic          c_n, d_n, oe_n;
  logic          tick, qend;

  assign tick = (qcnt == Q_LAST);
  assign qend = tick && (qtr == 2'd3);
  assign busy = (state != S_IDLE);

  always_comb begin
    state_n    = state;
    qcnt_n     = '0;
    qtr_n      = '0;
    bit_n      = bit_cnt;
    wait_n     = wait_cnt;
    frame_n    = frame;
    soft_rst_n = soft_rst;
    sccb_ok    = 1'b0;
    if (state inside {S_START, S_BITS, S_STOP, S_GAP}) begin
      qcnt_n = tick ? '0 : qcnt + 1'b1;
      qtr_n  = tick ? qtr + 2'd1 : qtr;
    end
    case (state)
      S_PWRUP: begin
        if (wait_cnt == PWRUP_LAST) begin
          state_n = S_IDLE;
          wait_n  = '0;
        end else begin
          wait_n = wait_cnt + 24'd1;
        end
      end
      S_IDLE: begin
        wait_n = '0;
        if (cfg_req) state_n = S_SETTLE;
      end
      // Three cycles let the ROM's index and registered data catch up before the latch.
      S_SETTLE: begin
        if (wait_cnt == 24'd2) begin
          state_n    = S_START;
          wait_n     = '0;
          frame_n    = {DEV_ADDR, 1'b1, cfg_data[15:8], 1'b1, cfg_data[7:0], 1'b1};
          soft_rst_n = (cfg_data[15:8] == 8'h12) && cfg_data[7];
        end else begin
          wait_n = wait_cnt + 24'd1;
        end
      end
      S_START: begin
        if (qend) begin
          state_n = S_BITS;
          bit_n   = '0;
        end
      end
      S_BITS: begin
        if (qend) begin
          if (bit_cnt == 5'd26) begin
            state_n = S_STOP;
          end else begin
            bit_n   = bit_cnt + 5'd1;
            frame_n = {frame[25:0], 1'b1};
          end
        end
      end
      S_STOP: begin
        if (qend) state_n = S_GAP;
      end
      S_GAP: begin
        if (qend) begin
          if (soft_rst) begin
            state_n = S_RSTW;
            wait_n  = '0;
          end else begin
            state_n = S_IDLE;
            sccb_ok = 1'b1;
          end
        end
      end
      S_RSTW: begin
        if (wait_cnt == RST_LAST) begin
          state_n = S_IDLE;
          sccb_ok = 1'b1;
        end else begin
          wait_n = wait_cnt + 24'd1;
        end
      end
      default: state_n = S_PWRUP;
    endcase
  end

  // Ack slots (bits 9/18/27) release the data line.
  always_comb begin
    c_n  = 1'b1;
    d_n  = 1'b1;
    oe_n = 1'b1;
    case (state_n)
      S_START: d_n = (qtr_n == 2'd0);
      S_BITS: begin
        c_n  = qtr_n[1];
        d_n  = frame_n[26];
        oe_n = !((bit_n == 5'd8) || (bit_n == 5'd17) || (bit_n == 5'd26));
      end
      S_STOP: begin
        c_n = (qtr_n != 2'd0);
        d_n = (qtr_n == 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_PWRUP;
      qcnt      <= '0;
      qtr       <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      frame     <= '1;
      soft_rst  <= 1'b0;
      sio_c     <= 1'b1;
      sio_d_out <= 1'b1;
      sio_d_oe  <= 1'b1;
    end else begin
      state     <= state_n;
      qcnt      <= qcnt_n;
      qtr       <= qtr_n;
      bit_cnt   <= bit_n;
      wait_cnt  <= wait_n;
      frame     <= frame_n;
      soft_rst  <= soft_rst_n;
      sio_c     <= c_n;
      sio_d_out <= d_n;
      sio_d_oe  <= oe_n;
    end
  end

endmodule

// File: tb/tb_ov2640_sccb_master.sv
// tb/tb_ov2640_sccb_master.sv - scoreboard bench for ov2640_sccb_master
module tb_ov2640_sccb_master;
  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_req;
  logic [15:0] cfg_data;
  logic        sccb_ok, busy, sio_c, sio_d_out, sio_d_oe;

  always #5 clk = ~clk;

  ov2640_sccb_master #(
    .CLK_FREQ(4_000_000), .SCCB_FREQ(100_000), .DEV_ADDR(8'h60),
    .PWRUP_WAIT(20), .RST_WAIT(50)
  ) dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_data(cfg_data),
    .sccb_ok(sccb_ok), .busy(busy), .sio_c(sio_c),
    .sio_d_out(sio_d_out), .sio_d_oe(sio_d_oe)
  );

  // Config ROM model: index advances on sccb_ok, data is registered one cycle later.
  logic        man_mode = 1'b0;
  logic        man_req = 1'b0;
  logic [15:0] man_data = 16'h0;
  logic [15:0] rom_tab [0:7];
  logic [15:0] rom_data = 16'h0;
  int          rom_n = 0;
  int          rom_idx = 0;

  assign cfg_req  = man_mode ? man_req : (rom_idx < rom_n);
  assign cfg_data = man_mode ? man_data : rom_data;

  always @(posedge clk) begin
    if (rst) rom_idx <= 0;
    else if (sccb_ok) rom_idx <= rom_idx + 1;
    rom_data <= rom_tab[rom_idx];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] val;
    int         lat;
    int         abs_l;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int checks = 0, failures = 0, ok_count = 0, last_ok = -1;
  int mst = 0, nb = 0, l_cyc = 0, rst_cyc = 0;
  logic pc = 1'b1, pd = 1'b1;
  logic [26:0] dv = '0, ov = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: decodes the bus on rising sio_c and scores each frame at its sccb_ok.
  always @(negedge clk) begin
    if (rst) begin
      mst = 0;
      nb  = 0;
    end else begin
      if (sccb_ok) ok_count++;
      if (sccb_ok && mst != 2) begin
        checks++;
        failures++;
        $display("FAIL ok_outside_frame actual=1 required=0 cyc=%0d", cyc);
      end
      case (mst)
        0: if (pc && sio_c && pd && !sio_d_out && sio_d_oe) begin
             mst = 1;
             nb = 0;
             l_cyc = cyc - (DIV + 1);
           end
        1: if (!pc && sio_c) begin
             dv = {dv[25:0], sio_d_out};
             ov = {ov[25:0], sio_d_oe};
             nb++;
             if (nb == 27) mst = 2;
           end
        default: if (sccb_ok) begin
             if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_frame actual=%0h required=none", dv);
             end else begin
               e = exp_q.pop_front();
               check("dev_byte", dv[26:19], 8'h60);
               check("addr_byte", dv[17:10], e.addr);
               check("val_byte", dv[8:1], e.val);
               check("oe_pattern", ov, 27'b111111110111111110111111110);
               check("ok_latency", cyc - l_cyc, e.lat);
               if (e.abs_l >= 0) check("latch_cycle", l_cyc, e.abs_l);
               if (e.gap >= 0) check("ok_to_latch", l_cyc - last_ok, e.gap);
             end
             mst = 0;
           end
      endcase
      if (sccb_ok) last_ok = cyc;
    end
    pc = sio_c;
    pd = sio_d_out;
  end

  task automatic push(input logic [15:0] w, input int lat, input int abs_l, input int gap);
    exp_t x;
    x.addr = w[15:8];
    x.val = w[7:0];
    x.lat = lat;
    x.abs_l = abs_l;
    x.gap = gap;
    exp_q.push_back(x);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1 rst = 1'b1;
    rom_n = n;
    @(posedge clk);
    #1 rst = 1'b0;
    rst_cyc = cyc;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_timeout", {31'b0, n >= maxc}, 0);
  endtask

  int okc0, bad, n;
  initial begin
    for (int i = 0; i < 8; i++) rom_tab[i] = 16'h0;

    // Power-up with nothing pending
    do_reset(0);
    check("rst_sio_c", sio_c, 1);
    check("rst_sio_d", sio_d_out, 1);
    check("rst_oe", sio_d_oe, 1);
    check("rst_busy", busy, 1);
    check("rst_ok", sccb_ok, 0);
    repeat (19) @(posedge clk);
    #1 check("pwrup_busy_last", busy, 1);
    @(posedge clk);
    #1 check("idle_busy", busy, 0);
    okc0 = ok_count;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 if (sio_c !== 1'b1 || sio_d_out !== 1'b1 || sccb_ok !== 1'b0) bad++;
    end
    check("idle_pins", bad, 0);
    check("idle_no_ok", ok_count - okc0, 0);

    // Single plain write
    rom_tab[0] = 16'h3C32;
    do_reset(1);
    push(16'h3C32, 1200, rst_cyc + 23, -1);
    wait_idle(3000);

    // Four-entry table, first entry is a soft reset
    rom_tab[0] = 16'h1280;
    rom_tab[1] = 16'h1240;
    rom_tab[2] = 16'h1101;
    rom_tab[3] = 16'h0A5C;
    do_reset(4);
    okc0 = ok_count;
    push(16'h1280, 1250, rst_cyc + 23, -1);
    push(16'h1240, 1200, -1, 4);
    push(16'h1101, 1200, -1, 4);
    push(16'h0A5C, 1200, -1, 4);
    wait_idle(8000);
    repeat (20) @(posedge clk);
    #1 check("table_ok_count", ok_count - okc0, 4);
    check("table_busy_end", busy, 0);

    // Reset in the middle of bit 12
    rom_tab[0] = 16'h3C32;
    rom_tab[1] = 16'h1101;
    do_reset(2);
    n = 0;
    while (!(mst == 1 && nb == 11) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("bit12_timeout", {31'b0, n >= 2000}, 0);
    repeat (25) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check("midrst_sio_c", sio_c, 1);
    check("midrst_sio_d", sio_d_out, 1);
    check("midrst_oe", sio_d_oe, 1);
    check("midrst_busy", busy, 1);
    rst = 1'b0;
    rst_cyc = cyc;
    push(16'h3C32, 1200, rst_cyc + 23, -1);
    push(16'h1101, 1200, -1, 4);
    wait_idle(4000);

    // One-cycle request, data changes after the latch
    man_mode = 1'b1;
    do_reset(0);
    repeat (25) @(posedge clk);
    okc0 = ok_count;
    @(posedge clk);
    #1 man_req = 1'b1;
    man_data = 16'h0B0C;
    push(16'h0B0C, 1200, cyc + 3, -1);
    @(posedge clk);
    #1 man_req = 1'b0;
    repeat (5) @(posedge clk);
    #1 man_data = 16'hFFFF;
    wait_idle(2000);
    repeat (200) @(posedge clk);
    #1 check("pulse_ok_count", ok_count - okc0, 1);
    check("pulse_busy_end", busy, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
